// File: rtl/coax_tx_buffer.sv
// Transmit word buffer: queues 10-bit words from the host and, on start,
// drains them back-to-back into the coax transmitter as one contiguous frame.
module coax_tx_buffer #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [9:0]               data,
  input  logic                     strobe,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     start,
  output logic                     busy,
  output logic [9:0]               tx_data,
  output logic                     tx_strobe,
  input  logic                     tx_ready,
  input  logic                     tx_active
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SENDING,
    WAIT_DONE
  } state_t;

  state_t          state, state_next;
  logic [9:0]      mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [AW:0]     count_next;
  logic            seen_active, seen_next;
  logic            overflow_next;
  logic            push, pop;

  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign busy      = (state != IDLE);
  assign tx_data   = mem[rd_ptr];
  assign tx_strobe = (state == SENDING) && tx_ready && !empty;

  // The full check uses this cycle's count, so a concurrent pop never makes room.
  assign push = strobe && !full;
  assign pop  = tx_strobe;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
  end

  always_comb begin
    state_next    = state;
    seen_next     = seen_active;
    overflow_next = overflow;
    case (state)
      IDLE: begin
        if (start && !empty) begin
          state_next    = SENDING;
          overflow_next = 1'b0;
        end
      end
      SENDING: begin
        if (count_next == '0) begin
          state_next = WAIT_DONE;
          seen_next  = 1'b0;
        end
      end
      WAIT_DONE: begin
        // The transmitter raises active a few cycles late; wait until it has been seen.
        if (seen_active && !tx_active) state_next = IDLE;
        if (tx_active) seen_next = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    if (strobe && full) overflow_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      seen_active <= 1'b0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      overflow    <= overflow_next;
      seen_active <= seen_next;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Storage is not reset; a reset only flushes the queue via the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end

endmodule

// File: doc/coax_tx_buffer.md
# coax_tx_buffer

Transmit word buffer that sits directly upstream of the coax transmitter and feeds its `data`/`strobe`/`ready` port. The host loads 10-bit words into a FIFO, then pulses `start`. The buffer then drains every queued word into the transmitter back-to-back, so the transmitter sends them as one contiguous frame. `busy` stays high until the transmitter's `active` falls after the last word.

## Interface
- `DEPTH`, default 16: FIFO depth in words; must be a power of 2, ≥ 4.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `data` input 10: word to enqueue.
- `strobe` input 1: enqueue `data` this cycle.
- `full` output 1: `count == DEPTH`.
- `empty` output 1: `count == 0`.
- `count` output $clog2(DEPTH)+1: words currently queued.
- `overflow` output 1: sticky; set when a write is dropped.
- `start` input 1: begin draining the queue as one frame.
- `busy` output 1: a frame is in progress (`state != IDLE`).
- `tx_data` output 10: FIFO head word; drives transmitter `data`.
- `tx_strobe` output 1: drives transmitter `strobe`.
- `tx_ready` input 1: from transmitter `ready`.
- `tx_active` input 1: from transmitter `active`.

## Operation
- **Storage**
  - FIFO storage is 10 × `DEPTH`.
  - Read pointer and write pointer are each $clog2(DEPTH) bits and wrap modulo `DEPTH`.
  - `count` is held as a separate register.
- **Push:** `strobe && !full` writes `mem[wr_ptr]`, increments `wr_ptr`, and increments `count`.
- **Overflow**
  - `strobe && full` drops the word and sets `overflow`.
  - The full check uses the current-cycle `full`. A concurrent pop does not make room for that write.
- **Pop:** `tx_strobe` increments `rd_ptr` and decrements `count`.
- **Simultaneous push and pop:** `count` is unchanged and both pointers advance.
- **Head word:** `tx_data = mem[rd_ptr]`, asynchronous read. It is valid whenever `!empty` and don't-care when `empty`.
- **Strobe generation:** `tx_strobe = (state == SENDING) && tx_ready && !empty`, combinational. This allows a refill in the same cycle `tx_ready` rises, which keeps the frame contiguous.
- **State machine**
  - `IDLE`:
    - `start && !empty` → `SENDING`, and clears `overflow`.
    - `start` while `empty` is ignored; `overflow` is unchanged.
  - `SENDING`:
    - Pops whenever `tx_strobe` is asserted.
    - When `count` will be 0 next cycle, → `WAIT_DONE` with `seen_active` cleared to 0.
    - Writes that arrive while still `SENDING` join the current frame.
  - `WAIT_DONE`:
    - `tx_strobe` is 0.
    - `seen_active` is set on `tx_active == 1`.
    - `seen_active && !tx_active` → `IDLE`.
    - Words written during `WAIT_DONE` stay queued for the next `start`.
- **Ignored inputs:** `start` is ignored while `busy`.
- **Reset**
  - Takes effect on the next edge regardless of state.
  - Clears pointers, `count`, `overflow`, `seen_active`, and state to `IDLE`.
  - The queue is flushed and FIFO memory contents are not cleared.
  - A reset mid-frame abandons the remaining words. The transmitter has its own reset.

## Timing
- **Reset values:** `busy` 0, `full` 0, `empty` 1, `count` 0, `overflow` 0, `tx_strobe` 0. `tx_data` is undefined.
- **Write latency:** a word written at edge N is visible in `count` and `empty` after edge N.
  - If it is the head, it appears on `tx_data` in cycle N+1.
- **Frame start:** `start` sampled at edge N gives `busy = 1` from cycle N+1. The first `tx_strobe` is in cycle N+1 if `tx_ready`.
- **Handshake:** exactly one pop per cycle with `tx_strobe`. `tx_data` is stable for the whole cycle in which `tx_strobe` is high.
- **`seen_active` guard:** the transmitter raises `active` about 3 cycles after accepting the first word. `seen_active` prevents a premature return to `IDLE` during that window.
- **Frame end:** `busy` falls on the edge after `tx_active` is sampled low.

## Test plan
- **Three-word frame:** load 0x3A5, 0x001, 0x2FF, then pulse `start`, with the real transmitter attached.
  - Exactly 3 `tx_strobe` pulses with `tx_data` in that order.
  - `count` goes 3→0.
  - `busy` falls one cycle after `tx_active` falls.
- **Overflow:** `DEPTH` = 4, write 5 words.
  - `full` = 1, `count` = 4, `overflow` = 1, and the fifth word is absent from the drain.
  - A following `start` clears `overflow`.
- **Start while empty:** pulse `start` with the queue empty.
  - `busy` stays 0 and `tx_strobe` is never asserted.
- **Push and pop together:** hold `count` at 2 mid-frame and assert `strobe` in the same cycle as `tx_strobe`.
  - `count` remains 2.
  - The new word is transmitted within the same frame (single `tx_active` pulse).
- **Wrap-around:** `DEPTH` = 4, run 3 frames of 3 words each.
  - Pointers wrap and every word is emitted in FIFO order with no loss or duplication.
- **Reset mid-frame:** assert `reset` after the first `tx_strobe` of a 4-word frame.
  - Next cycle: `busy` = 0, `empty` = 1, `count` = 0, `tx_strobe` = 0.
  - No further strobes until a new load and `start`.
